// File: rtl/led_shift_ctrl.sv
// LED shift register driven by debounced button pulses: manual shifts, double-press auto-rotate.
// Latency: one registered stage; a pulse at edge N shows on led/mode/shift_strobe after edge N+1.
// No backpressure: a pulse is accepted on every cycle, and any pulse in auto mode returns to manual.
module led_shift_ctrl #(
  parameter int                WIDTH        = 8,
  parameter int                TICK_DIV     = 50_000_000,
  parameter int                DBL_WINDOW   = 30_000_000,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(8'h01)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        btn_pulse,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  led,
  output logic [1:0]        mode,
  output logic              shift_strobe
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (DBL_WINDOW > 1) ? $clog2(DBL_WINDOW) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(DBL_WINDOW - 1);

  localparam logic [1:0] MANUAL     = 2'b00;
  localparam logic [1:0] AUTO_LEFT  = 2'b01;
  localparam logic [1:0] AUTO_RIGHT = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [TW-1:0]    tick_cnt, tick_nxt;
  logic [WW-1:0]    win_cnt, win_nxt;
  logic             armed, armed_nxt;
  logic             armed_dir, dir_nxt;
  logic [WIDTH-1:0] led_nxt;
  logic [1:0]       mode_nxt;
  logic             strobe_nxt;

  // Next-state decode: manual shifting with a double-press window, or timed rotation in auto mode.
  always_comb begin
    led_nxt    = led;
    mode_nxt   = mode;
    strobe_nxt = 1'b0;
    tick_nxt   = tick_cnt;
    win_nxt    = win_cnt;
    armed_nxt  = armed;
    dir_nxt    = armed_dir;

    case (mode)
      MANUAL: begin
        case (btn_pulse)
          2'b01: begin
            if (armed && (armed_dir == DIR_LEFT)) begin
              // Second left press inside the window: start rotating, no shift this cycle.
              mode_nxt  = AUTO_LEFT;
              armed_nxt = 1'b0;
              tick_nxt  = '0;
              win_nxt   = '0;
            end else begin
              led_nxt    = {led[WIDTH-2:0], serial_in};
              strobe_nxt = 1'b1;
              armed_nxt  = 1'b1;
              dir_nxt    = DIR_LEFT;
              win_nxt    = '0;
            end
          end
          2'b10: begin
            if (armed && (armed_dir == DIR_RIGHT)) begin
              mode_nxt  = AUTO_RIGHT;
              armed_nxt = 1'b0;
              tick_nxt  = '0;
              win_nxt   = '0;
            end else begin
              led_nxt    = {serial_in, led[WIDTH-1:1]};
              strobe_nxt = 1'b1;
              armed_nxt  = 1'b1;
              dir_nxt    = DIR_RIGHT;
              win_nxt    = '0;
            end
          end
          2'b11: begin
            // Both buttons together restore the start pattern and forget any pending press.
            led_nxt    = INIT_PATTERN;
            strobe_nxt = 1'b1;
            armed_nxt  = 1'b0;
            win_nxt    = '0;
          end
          default: begin
            // Idle: age the double-press window; it closes after its last counted cycle.
            if (armed) begin
              if (win_cnt == WIN_LAST) begin
                armed_nxt = 1'b0;
                win_nxt   = '0;
              end else begin
                win_nxt = win_cnt + WW'(1);
              end
            end
          end
        endcase
      end

      AUTO_LEFT, AUTO_RIGHT: begin
        if (btn_pulse != 2'b00) begin
          // Any press leaves auto mode; it takes priority over a coinciding tick.
          mode_nxt  = MANUAL;
          tick_nxt  = '0;
          armed_nxt = 1'b0;
          win_nxt   = '0;
        end else if (tick_cnt == TICK_LAST) begin
          tick_nxt   = '0;
          strobe_nxt = 1'b1;
          if (mode == AUTO_LEFT) begin
            led_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
          end else begin
            led_nxt = {led[0], led[WIDTH-1:1]};
          end
        end else begin
          tick_nxt = tick_cnt + TW'(1);
        end
      end

      default: begin
        // Unused encoding: fall back to manual without touching the pattern.
        mode_nxt  = MANUAL;
        tick_nxt  = '0;
        armed_nxt = 1'b0;
        win_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts auto mode and any open window at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led          <= INIT_PATTERN;
      mode         <= MANUAL;
      shift_strobe <= 1'b0;
      tick_cnt     <= '0;
      win_cnt      <= '0;
      armed        <= 1'b0;
      armed_dir    <= DIR_LEFT;
    end else begin
      led          <= led_nxt;
      mode         <= mode_nxt;
      shift_strobe <= strobe_nxt;
      tick_cnt     <= tick_nxt;
      win_cnt      <= win_nxt;
      armed        <= armed_nxt;
      armed_dir    <= dir_nxt;
    end
  end

endmodule
